lc3_decode_unit: RTL and testbench

- Decode stage of the LC-3 pipeline. Drives the decode_out bus (IR, E_control, npc_out, W_control, Mem_control) that the execute and writeback stages consume.
- Registers the fetched instruction and its next-PC.
- Produces registered execute, writeback and memory control words one cycle after an enabled decode.
- Acts as the RTL producer that the decode_out agent checks, and that the agent's responder mode replaces.

---
 rtl/lc3_decode_pkg.sv | 65 ++++++
 rtl/lc3_decode_ctrl.sv | 44 ++++
 rtl/lc3_decode_unit.sv | 66 ++++++
 tb/tb_lc3_decode_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_decode_pkg.sv
// LC-3 decode package: opcode encoding, E_control field layout, control encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3_decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    // E_control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int E_ALU_HI    = 5;
    localparam int E_ALU_LO    = 4;
    localparam int E_PCSEL1_HI = 3;
    localparam int E_PCSEL1_LO = 2;
    localparam int E_PCSEL2    = 1;
    localparam int E_OP2SEL    = 0;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;

    localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    typedef struct packed {
        logic [5:0] e;
        logic [1:0] w;
        logic       mem;
    } ctrl_word_t;

    function automatic logic [5:0] make_e(input logic [1:0] alu,
                                          input logic [1:0] pcsel1,
                                          input logic       pcsel2,
                                          input logic       op2sel);
        logic [5:0] e;
        e = '0;
        e[E_ALU_HI:E_ALU_LO]       = alu;
        e[E_PCSEL1_HI:E_PCSEL1_LO] = pcsel1;
        e[E_PCSEL2]                = pcsel2;
        e[E_OP2SEL]                = op2sel;
        return e;
    endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// LC-3 control-word decoder: opcode + IR[5] -> {E_control, W_control, Mem_control}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
// Ports: opcode (IR[15:12]), imm_bit (IR[5], 1 = immediate form), ctrl (decoded word).
module lc3_decode_ctrl
    import lc3_decode_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic        imm_bit,
    output ctrl_word_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_ADD: ctrl.e = make_e(ALU_PASS, PCSEL1_OFF11, 1'b0, ~imm_bit);
            OP_AND: ctrl.e = make_e(ALU_AND,  PCSEL1_OFF11, 1'b0, ~imm_bit);
            OP_NOT: ctrl.e = make_e(ALU_NOT,  PCSEL1_OFF11, 1'b0, 1'b0);
            OP_BR:  ctrl.e = make_e(ALU_PASS, PCSEL1_OFF9,  1'b1, 1'b0);
            OP_JMP: ctrl.e = make_e(ALU_PASS, PCSEL1_ZERO,  1'b0, 1'b0);
            OP_LD, OP_LDI: begin
                ctrl.e   = make_e(ALU_PASS, PCSEL1_OFF9, 1'b1, 1'b0);
                ctrl.w   = W_MEM;
                ctrl.mem = (opcode == OP_LDI);
            end
            OP_ST, OP_STI: begin
                ctrl.e   = make_e(ALU_PASS, PCSEL1_OFF9, 1'b1, 1'b0);
                ctrl.mem = (opcode == OP_STI);
            end
            OP_LEA: begin
                ctrl.e = make_e(ALU_PASS, PCSEL1_OFF9, 1'b1, 1'b0);
                ctrl.w = W_PC;
            end
            OP_LDR: begin
                ctrl.e = make_e(ALU_PASS, PCSEL1_OFF6, 1'b0, 1'b0);
                ctrl.w = W_MEM;
            end
            OP_STR: ctrl.e = make_e(ALU_PASS, PCSEL1_OFF6, 1'b0, 1'b0);
            // JSR, RTI, reserved and TRAP produce no controls
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/lc3_decode_unit.sv
// LC-3 decode stage: registers IR/next-PC and the decoded execute/writeback/memory controls.
// Latency: 1 cycle from an enabled decode to valid outputs.
// Backpressure: enable_decode=0 stalls; every output holds its value.
// Ports: clock, reset (async active-high), enable_decode, instr_dout, npc_in ->
//        IR, npc_out, E_control, W_control, Mem_control, decode_valid
//        (+ illegal_op when LC3_DECODE_ILLEGAL_EN is defined).
module lc3_decode_unit
    import lc3_decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_decode,
    input  logic [INSTR_W-1:0] instr_dout,
    input  logic [PC_W-1:0]    npc_in,
    output logic [INSTR_W-1:0] IR,
    output logic [PC_W-1:0]    npc_out,
    output logic [5:0]         E_control,
    output logic [1:0]         W_control,
    output logic               Mem_control,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic               illegal_op,
`endif
    output logic               decode_valid
);

    ctrl_word_t ctrl_nxt;

    // Decode from the incoming word, not IR, so back-to-back enables each get fresh controls.
    lc3_decode_ctrl u_ctrl (
        .opcode  (instr_dout[15:12]),
        .imm_bit (instr_dout[5]),
        .ctrl    (ctrl_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_control    <= '0;
            W_control    <= '0;
            Mem_control  <= 1'b0;
            decode_valid <= 1'b0;
        end else if (enable_decode) begin
            IR           <= instr_dout;
            npc_out      <= npc_in;
            E_control    <= ctrl_nxt.e;
            W_control    <= ctrl_nxt.w;
            Mem_control  <= ctrl_nxt.mem;
            decode_valid <= 1'b1;
        end
    end

`ifdef LC3_DECODE_ILLEGAL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if (enable_decode) begin
            illegal_op <= (instr_dout[15:12] == OP_RES) || (instr_dout[15:12] == OP_RTI);
        end
    end
`endif

endmodule

// File: tb/tb_lc3_decode_unit.sv
module tb_lc3_decode_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_decode = 1'b0;
    logic [15:0] instr_dout = '0;
    logic [15:0] npc_in = '0;
    logic [15:0] IR, npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control, decode_valid;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic        illegal_op;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    lc3_decode_unit #(.INSTR_W(16), .PC_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_control     (E_control),
        .W_control     (W_control),
        .Mem_control   (Mem_control),
`ifdef LC3_DECODE_ILLEGAL_EN
        .illegal_op    (illegal_op),
`endif
        .decode_valid  (decode_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per-opcode table transcribed from the opcode list; ADD/AND get op2select from IR[5].
    logic [5:0] tab_e   [16];
    logic [1:0] tab_w   [16];
    logic       tab_mem [16];

    logic [15:0] m_ir, m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_mem, m_vld, m_ill;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab_e[i] = 6'b0; tab_w[i] = 2'b0; tab_mem[i] = 1'b0;
        end
        tab_e[4'h1] = 6'b000000;               // ADD (op2 added below)
        tab_e[4'h5] = 6'b010000;               // AND
        tab_e[4'h9] = 6'b100000;               // NOT
        tab_e[4'h0] = 6'b000110;               // BR
        tab_e[4'hC] = 6'b001100;               // JMP
        tab_e[4'h2] = 6'b000110; tab_w[4'h2] = 2'b01;                       // LD
        tab_e[4'hA] = 6'b000110; tab_w[4'hA] = 2'b01; tab_mem[4'hA] = 1'b1; // LDI
        tab_e[4'h3] = 6'b000110;                                            // ST
        tab_e[4'hB] = 6'b000110; tab_mem[4'hB] = 1'b1;                      // STI
        tab_e[4'hE] = 6'b000110; tab_w[4'hE] = 2'b10;                       // LEA
        tab_e[4'h6] = 6'b001000; tab_w[4'h6] = 2'b01;                       // LDR
        tab_e[4'h7] = 6'b001000;                                            // STR
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_mem = 0; m_vld = 0; m_ill = 0;
        end else if (enable_decode) begin
            int op;
            op    = int'(instr_dout[15:12]);
            m_ir  = instr_dout;
            m_npc = npc_in;
            m_e   = tab_e[op];
            if (op == 1 || op == 5) m_e[0] = ~instr_dout[5];
            m_w   = tab_w[op];
            m_mem = tab_mem[op];
            m_vld = 1'b1;
            m_ill = (op == 13 || op == 8);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cmp_ir",  32'(IR),          32'(m_ir));
            chk("cmp_npc", 32'(npc_out),     32'(m_npc));
            chk("cmp_e",   32'(E_control),   32'(m_e));
            chk("cmp_w",   32'(W_control),   32'(m_w));
            chk("cmp_mem", 32'(Mem_control), 32'(m_mem));
            chk("cmp_vld", 32'(decode_valid), 32'(m_vld));
`ifdef LC3_DECODE_ILLEGAL_EN
            chk("cmp_ill", 32'(illegal_op),  32'(m_ill));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    // Drive inputs just after an edge, then let the next edge capture them; look #2 after it.
    task automatic step(input logic en, input logic [15:0] instr, input logic [15:0] npc);
        enable_decode = en;
        instr_dout    = instr;
        npc_in        = npc;
        @(posedge clock);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [15:0] ir, input logic [15:0] npc,
                              input logic [5:0] e, input logic [1:0] w, input logic mem,
                              input logic vld);
        chk({name, "_ir"},  32'(IR),           32'(ir));
        chk({name, "_npc"}, 32'(npc_out),      32'(npc));
        chk({name, "_e"},   32'(E_control),    32'(e));
        chk({name, "_w"},   32'(W_control),    32'(w));
        chk({name, "_mem"}, 32'(Mem_control),  32'(mem));
        chk({name, "_vld"}, 32'(decode_valid), 32'(vld));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #2;
        cmp_en = 1'b1;
        expect_out("reset", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 16'h1283, 16'h3001);
        step(1'b0, 16'h1283, 16'h3001);
        expect_out("idle", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);

        step(1'b1, 16'h1283, 16'h3001);
        expect_out("add_reg", 16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b1);
        step(1'b1, 16'h12A5, 16'h3002);
        expect_out("add_imm", 16'h12A5, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b1);
        step(1'b1, 16'h5283, 16'h3003);
        expect_out("and_reg", 16'h5283, 16'h3003, 6'b010001, 2'b00, 1'b0, 1'b1);
        step(1'b1, 16'h927F, 16'h3004);
        expect_out("not",     16'h927F, 16'h3004, 6'b100000, 2'b00, 1'b0, 1'b1);
        step(1'b1, 16'hA003, 16'h3005);
        expect_out("ldi",     16'hA003, 16'h3005, 6'b000110, 2'b01, 1'b1, 1'b1);
        step(1'b1, 16'hE005, 16'h3006);
        expect_out("lea",     16'hE005, 16'h3006, 6'b000110, 2'b10, 1'b0, 1'b1);
        step(1'b1, 16'h7042, 16'h3007);
        expect_out("str",     16'h7042, 16'h3007, 6'b001000, 2'b00, 1'b0, 1'b1);

        // stall: JMP presented while enable is low must not be taken
        step(1'b1, 16'h1283, 16'h3010);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'hC1C0, 16'h3011);
            expect_out("stall", 16'h1283, 16'h3010, 6'b000001, 2'b00, 1'b0, 1'b1);
        end
        step(1'b1, 16'hC1C0, 16'h3011);
        expect_out("jmp", 16'hC1C0, 16'h3011, 6'b001100, 2'b00, 1'b0, 1'b1);

        step(1'b1, 16'hD000, 16'h3012);
        expect_out("res", 16'hD000, 16'h3012, 6'b000000, 2'b00, 1'b0, 1'b1);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("ill_set", 32'(illegal_op), 32'd1);
`endif
        step(1'b1, 16'h1283, 16'h3013);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("ill_clr", 32'(illegal_op), 32'd0);
`endif

        // sweep every opcode with both IR[5] values; the compare process checks each
        for (int i = 0; i < 32; i++) begin
            logic [3:0] op;
            logic       b5;
            op = 4'(i >> 1);
            b5 = i[0];
            step(1'b1, {op, 6'h0A, b5, 5'h05}, 16'h4000 + 16'(i));
        end

        // asynchronous reset between edges
        step(1'b1, 16'hA003, 16'h5000);
        reset = 1'b1;
        #1;
        expect_out("async_rst", 16'h0, 16'h0, 6'b0, 2'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        step(1'b1, 16'h2005, 16'h5001);
        expect_out("post_rst_ld", 16'h2005, 16'h5001, 6'b000110, 2'b01, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
